if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clk and rst_n, with all state updated on the rising edge of clk.
REQ-002 Port clk, input, 1 bit: the single clock.
REQ-003 Port rst_n, input, 1 bit: synchronous active-low reset.
REQ-004 Port Stall, input, 1 bit: hazard hold, freezes PC and the IF/ID register.
REQ-005 Port BranchTaken, input, 1 bit, with BranchAddr, input, 32 bits: branch redirect request and its target.
REQ-006 Port JR, input, 1 bit, with JRAddr, input, 32 bits: register-jump redirect and its target (rs value).
REQ-007 Port J, input, 1 bit: jump decoded from the current Instruction_id.
REQ-008 Port imem_req, output, 1 bit, with imem_addr, output, 32 bits: instruction memory request and its word address.
REQ-009 Port imem_ack, input, 1 bit, with imem_rdata, input, 32 bits: response valid and instruction word; ack may come in the same cycle as req or any later cycle.
REQ-010 Port Instruction_id, output, 32 bits; PC_plus4_id, output, 32 bits; valid_id, output, 1 bit: the IF/ID register contents.

Function
REQ-011 The block SHALL implement three states: FETCH, HOLD and DRAIN.
REQ-012 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal PC; once asserted, req and addr SHALL hold stable until imem_ack.
REQ-013 FETCH, ack, no Stall, no redirect: IF/ID SHALL load {imem_rdata, PC+4, valid=1}, PC SHALL become PC+4 and the state SHALL stay FETCH, giving 1 instruction/cycle with zero-latency memory.
REQ-014 FETCH, ack, Stall, no redirect: imem_rdata SHALL be captured in a skid buffer, PC and IF/ID SHALL be held, and the state SHALL go to HOLD with imem_req=0.
REQ-015 HOLD, Stall deasserted: the skid buffer SHALL be moved to IF/ID, PC SHALL become PC+4 and the state SHALL go to FETCH.
REQ-016 Any cycle with Stall=1 and no redirect: Instruction_id, PC_plus4_id and valid_id SHALL be unchanged.
REQ-017 Redirect SHALL be the OR of BranchTaken, JR and J.
REQ-018 Redirect target priority SHALL be BranchTaken (BranchAddr), then JR (JRAddr), then J ({PC_plus4_id[31:28], Instruction_id[25:0], 2'b00}).
REQ-019 Target bits [1:0] SHALL be forced to 00.
REQ-020 Redirect SHALL override Stall.
REQ-021 On redirect, IF/ID SHALL load the bubble {32'h0, 32'h0, valid=0}; all-zero is the decoder's NOP.
REQ-022 Redirect in FETCH with imem_ack the same cycle: rdata SHALL be discarded, PC SHALL become the target, and the state SHALL stay FETCH.
REQ-023 Redirect in FETCH without ack: PC SHALL become the target and the state SHALL go to DRAIN; imem_req/imem_addr SHALL keep the old request.
REQ-024 DRAIN: imem_req SHALL stay 1 with the old address, which is held in a separate register; on ack, rdata SHALL be discarded and the state SHALL go to FETCH.
REQ-025 Further redirects in DRAIN SHALL update PC only (latest wins).
REQ-026 Redirect in HOLD: the skid buffer SHALL be dropped, PC SHALL become the target and the state SHALL go to FETCH.
REQ-027 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 0.

Reset
REQ-028 While rst_n=0 at a clock edge: PC=0, state=FETCH, imem_req=0, Instruction_id=0, PC_plus4_id=0, valid_id=0, and the skid buffer and DRAIN address cleared.
REQ-029 In the first cycle after reset release, imem_req SHALL be 1 with imem_addr=0.
REQ-030 Reset mid-operation SHALL abandon any outstanding request, and acks arriving after reset SHALL be ignored unless imem_req=1.

Structure
REQ-031 Shared package mips_pkg SHALL hold the state encoding (FETCH, HOLD, DRAIN), RESET_PC=32'h0 and NOP_INSTR=32'h0.
REQ-032 One sub-module, if_id_reg, SHALL hold the IF/ID register with load, hold and bubble controls; the FSM and PC stay in if_stage.

Verification
REQ-033 Zero-latency memory, 4 instructions, no stall: imem_addr 0,4,8,C on consecutive cycles; valid_id=1 with PC_plus4_id 4,8,C,10.
REQ-034 Ack with Stall=1 for 3 cycles: IF/ID holds the prior word and imem_req=0; the buffered word appears the cycle after Stall drops, then the next fetch is at +4.
REQ-035 BranchTaken=1 and J=1 together, BranchAddr=32'h0000_0103: next imem_addr=32'h100 and the IF/ID bubble has valid_id=0, Instruction_id=0.
REQ-036 Ack latency 3, JR to 32'h200 one cycle after req: old address held until ack, that rdata dropped (valid_id stays 0), then the fetch is at 32'h200.
REQ-037 Instruction_id=32'h0800_0010, PC_plus4_id=32'h1000_0004, J=1: next imem_addr=32'h1000_0040.
REQ-038 rst_n=0 for one edge during DRAIN: all outputs zero, then imem_addr=0 with imem_req=1 the next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: FSM encoding, reset PC and the NOP word.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } if_state_e;

  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam logic [31:0] NOP_INSTR = 32'h0;

  // Redirect targets are word addresses; low two bits are always cleared.
  function automatic logic [31:0] align4(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise hold.
import mips_pkg::*;

module if_id_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  // Register update: reset / bubble to NOP / load new word / hold.
  always_ff @(posedge clk) begin
    if (!rst_n || bubble) begin
      instr <= NOP_INSTR;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_in;
      pc4   <= pc4_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, fetch FSM (FETCH/HOLD/DRAIN) and IF/ID register.
import mips_pkg::*;

module if_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchAddr,
  input  logic        JR,
  input  logic [31:0] JRAddr,
  input  logic        J,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_id,
  output logic [31:0] PC_plus4_id,
  output logic        valid_id
);

  if_state_e   state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] skid, skid_nxt;
  logic [31:0] drain_addr, drain_nxt;
  logic [31:0] pc_plus4, target, ld_instr;
  logic        redirect, ack, ld, bub;

  assign pc_plus4 = pc + 32'd4;
  assign redirect = BranchTaken | JR | J;

  // Request is gated by rst_n so acks during reset are never consumed.
  assign imem_req  = rst_n && (state != HOLD);
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;
  assign ack       = imem_req & imem_ack;

  // Redirect target: branch beats register jump beats J.
  always_comb begin
    target = 32'h0;
    if (BranchTaken)  target = align4(BranchAddr);
    else if (JR)      target = align4(JRAddr);
    else if (J)       target = {PC_plus4_id[31:28], Instruction_id[25:0], 2'b00};
  end

  // Next-state and IF/ID controls. Redirect overrides Stall everywhere;
  // an idle unstalled cycle feeds a bubble so decode never re-executes a word.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    skid_nxt  = skid;
    drain_nxt = drain_addr;
    ld        = 1'b0;
    bub       = 1'b0;
    ld_instr  = imem_rdata;
    case (state)
      FETCH: begin
        if (redirect) begin
          pc_nxt = target;
          bub    = 1'b1;
          if (!ack) begin
            drain_nxt = pc;
            state_nxt = DRAIN;
          end
        end else if (ack) begin
          if (Stall) begin
            skid_nxt  = imem_rdata;
            state_nxt = HOLD;
          end else begin
            ld     = 1'b1;
            pc_nxt = pc_plus4;
          end
        end else if (!Stall) begin
          bub = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_nxt    = target;
          bub       = 1'b1;
          state_nxt = FETCH;
        end else if (!Stall) begin
          ld        = 1'b1;
          ld_instr  = skid;
          pc_nxt    = pc_plus4;
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        if (redirect) begin
          pc_nxt = target;
          bub    = 1'b1;
        end else if (!Stall) begin
          bub = 1'b1;
        end
        if (ack) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // State, PC, skid buffer and drain address registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      skid       <= 32'h0;
      drain_addr <= 32'h0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      skid       <= skid_nxt;
      drain_addr <= drain_nxt;
    end
  end

  if_id_reg u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .bubble   (bub),
    .instr_in (ld_instr),
    .pc4_in   (pc_plus4),
    .instr    (Instruction_id),
    .pc4      (PC_plus4_id),
    .valid    (valid_id)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a variable-latency memory and an IF/ID scoreboard.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n, Stall, BranchTaken, JR, J;
  logic [31:0] BranchAddr, JRAddr;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] Instruction_id, PC_plus4_id;
  logic        valid_id;

  int errors = 0;
  int checks = 0;
  int lat    = 0;
  int wait_cnt;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_t;
  ifid_t sb[$];

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchAddr(BranchAddr),
    .JR(JR), .JRAddr(JRAddr), .J(J),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Instruction_id(Instruction_id), .PC_plus4_id(PC_plus4_id), .valid_id(valid_id)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h1000_0000) ? 32'h0800_0010 : (32'hC000_0000 ^ a);
  endfunction

  // Memory model: ack once the request has waited lat cycles.
  assign imem_ack   = imem_req && (wait_cnt >= lat);
  assign imem_rdata = mem(imem_addr);
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    ifid_t e;
    e.instr = mem(a);
    e.pc4   = a + 32'd4;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    ifid_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty got %h expected entry", tag, Instruction_id);
    end else begin
      e = sb.pop_front();
      chk({tag, "_instr"}, Instruction_id, e.instr);
      chk({tag, "_pc4"},   PC_plus4_id,    e.pc4);
      chk({tag, "_valid"}, {31'h0, valid_id}, 32'h1);
    end
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, {31'h0, valid_id}, 32'h0);
    chk({tag, "_instr"}, Instruction_id, 32'h0);
  endtask

  initial begin
    wait_cnt = 0;
    rst_n = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; JR = 1'b0; J = 1'b0;
    BranchAddr = 32'h0; JRAddr = 32'h0;
    tick(); tick();
    chk("rst_req",   {31'h0, imem_req}, 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_pc4",   PC_plus4_id, 32'h0);
    chk_bubble("rst");

    // Release reset: fetch at 0 immediately, then streaming zero-latency fetches.
    rst_n = 1'b1; #1;
    chk("rel_req", {31'h0, imem_req}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("stream_addr", imem_addr, 32'(4 * i));
      push(32'(4 * i));
      tick();
      pop_chk("stream");
    end

    // Ack while stalled: word parks in the skid buffer for 3 cycles.
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_req",   {31'h0, imem_req}, 32'h0);
      chk("stall_instr", Instruction_id, mem(32'hC));
      chk("stall_pc4",   PC_plus4_id, 32'h10);
    end
    Stall = 1'b0;
    push(32'h10);
    tick();
    pop_chk("skid");
    chk("skid_next_addr", imem_addr, 32'h14);

    // Branch and J together: branch wins, target low bits cleared.
    BranchTaken = 1'b1; J = 1'b1; BranchAddr = 32'h0000_0103;
    tick();
    BranchTaken = 1'b0; J = 1'b0;
    chk("br_addr", imem_addr, 32'h100);
    chk_bubble("br");
    push(32'h100);
    tick();
    pop_chk("br_fetch");

    // JR during a 3-cycle memory wait: old request drained, data dropped.
    lat = 3;
    tick();
    chk_bubble("wait");
    JR = 1'b1; JRAddr = 32'h200;
    tick();
    JR = 1'b0;
    chk("drain_addr0", imem_addr, 32'h104);
    chk("drain_req0",  {31'h0, imem_req}, 32'h1);
    tick();
    chk("drain_addr1", imem_addr, 32'h104);
    tick();
    chk("drain_done_addr", imem_addr, 32'h200);
    chk_bubble("drain_done");
    lat = 0;
    push(32'h200);
    tick();
    pop_chk("jr_fetch");

    // J target built from the current IF/ID contents.
    BranchTaken = 1'b1; BranchAddr = 32'h1000_0000;
    tick();
    BranchTaken = 1'b0;
    push(32'h1000_0000);
    tick();
    pop_chk("j_src");
    J = 1'b1;
    tick();
    J = 1'b0;
    chk("j_addr", imem_addr, 32'h1000_0040);
    chk_bubble("j");

    // PC wraps modulo 2^32.
    BranchTaken = 1'b1; BranchAddr = 32'hFFFF_FFFF;
    tick();
    BranchTaken = 1'b0;
    chk("wrap_tgt", imem_addr, 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC);
    tick();
    pop_chk("wrap");
    chk("wrap_addr", imem_addr, 32'h0);

    // Redirect while in HOLD drops the skid word.
    Stall = 1'b1;
    tick();
    chk("hold_req", {31'h0, imem_req}, 32'h0);
    BranchTaken = 1'b1; BranchAddr = 32'h400;
    tick();
    BranchTaken = 1'b0; Stall = 1'b0;
    chk("hold_redir_addr", imem_addr, 32'h400);
    chk("hold_redir_req",  {31'h0, imem_req}, 32'h1);
    chk_bubble("hold_redir");

    // Reset while draining abandons the request.
    lat = 3;
    JR = 1'b1; JRAddr = 32'h300;
    tick();
    JR = 1'b0;
    chk("pre_rst_drain", imem_addr, 32'h400);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_req",  {31'h0, imem_req}, 32'h0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_pc4",  PC_plus4_id, 32'h0);
    chk_bubble("mid_rst");
    rst_n = 1'b1; #1;
    chk("post_rst_req",  {31'h0, imem_req}, 32'h1);
    chk("post_rst_addr", imem_addr, 32'h0);
    lat = 0;
    push(32'h0);
    tick();
    pop_chk("post_rst_fetch");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
